// File: rtl/task_3_input.sv
// Packet input stage: byte FIFO between a manager stream and the task core,
// store-and-forward by default, cut-through when TASK_3_INPUT_CUT_THROUGH_EN is defined.
module task_3_input #(
  parameter int DEPTH = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tmanager_valid,
  input  logic [7:0]  i_tdata,
  input  logic        i_tdata_last,
  input  logic [11:0] i_packet_size_in_bytes,
  output logic        o_tinput_ready,
  input  logic        i_core_ready,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_input_last,
  output logic        o_busy,
  output logic        o_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  localparam logic [1:0] s_IDLE  = 2'd0;
  localparam logic [1:0] s_RECV  = 2'd1;
  localparam logic [1:0] s_DRAIN = 2'd2;
  localparam logic [1:0] s_FLUSH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ_q, occ_d;
  logic [11:0]   count_q, size_q;
  logic [11:0]   count_inc, size_eff;
  logic          error_q;
  logic          empty, full;
  logic          wr_en, rd_en;
  logic          in_ready, out_valid, out_last, busy;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == FULL_OCC);

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      s_IDLE: in_ready = 1'b1;
      s_RECV: begin
        in_ready = !full;
        busy     = 1'b1;
`ifdef TASK_3_INPUT_CUT_THROUGH_EN
        out_valid = !empty;
`endif
      end
      s_FLUSH: begin
        busy      = 1'b1;
        out_valid = !empty;
      end
      s_DRAIN: begin
        busy      = 1'b1;
        out_valid = !empty;
        out_last  = !empty && (occ_q == (AW+1)'(1));
      end
      default: ;
    endcase
  end

  // Reset forces every output low, whatever the state register still holds.
  assign o_tinput_ready = in_ready && !i_rst;
  assign o_data_valid   = out_valid && !i_rst;
  assign o_input_last   = out_last && !i_rst;
  assign o_busy         = busy && !i_rst;
  assign o_error        = error_q && !i_rst;
  assign o_data         = i_rst ? 8'h00 : mem[rd_ptr_q];

  assign wr_en = i_tmanager_valid && o_tinput_ready;
  assign rd_en = o_data_valid && i_core_ready;

  always_comb begin
    occ_d = occ_q;
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // The first byte of a packet compares against the size presented with it.
  always_comb begin
    if (state_q == s_IDLE) begin
      count_inc = 12'd1;
      size_eff  = i_packet_size_in_bytes;
    end else begin
      count_inc = (count_q == 12'hFFF) ? count_q : count_q + 12'd1;
      size_eff  = size_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      s_IDLE: begin
        if (wr_en) state_d = i_tdata_last ? s_DRAIN : s_RECV;
      end
      s_RECV: begin
        if (wr_en && i_tdata_last) state_d = s_DRAIN;
`ifndef TASK_3_INPUT_CUT_THROUGH_EN
        else if (wr_en && occ_d == FULL_OCC) state_d = s_FLUSH;
`endif
      end
      s_FLUSH: begin
        if (occ_d == '0) state_d = s_RECV;
      end
      s_DRAIN: begin
        if (occ_d == '0) state_d = s_IDLE;
      end
      default: state_d = s_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= s_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
      size_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        count_q  <= count_inc;
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && state_q == s_IDLE) size_q <= i_packet_size_in_bytes;
      error_q <= wr_en && i_tdata_last && (count_inc != size_eff);
    end
  end

  // NOTE: storage is not reset; pointers and occupancy alone define valid data.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q] <= i_tdata;
  end

endmodule

// File: tb/tb_task_3_input.sv
// Bench for task_3_input at DEPTH=4: per-cycle vector table, directed
// flush/reset/cut-through sequences, then random packets against a scoreboard.
module tb_task_3_input;

  localparam int TB_DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_tmanager_valid;
  logic [7:0]  i_tdata;
  logic        i_tdata_last;
  logic [11:0] i_packet_size_in_bytes;
  logic        o_tinput_ready;
  logic        i_core_ready;
  logic [7:0]  o_data;
  logic        o_data_valid;
  logic        o_input_last;
  logic        o_busy;
  logic        o_error;

  task_3_input #(.DEPTH(TB_DEPTH)) dut (
    .i_clk                  (i_clk),
    .i_rst                  (i_rst),
    .i_tmanager_valid       (i_tmanager_valid),
    .i_tdata                (i_tdata),
    .i_tdata_last           (i_tdata_last),
    .i_packet_size_in_bytes (i_packet_size_in_bytes),
    .o_tinput_ready         (o_tinput_ready),
    .i_core_ready           (i_core_ready),
    .o_data                 (o_data),
    .o_data_valid           (o_data_valid),
    .o_input_last           (o_input_last),
    .o_busy                 (o_busy),
    .o_error                (o_error)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int acc_got[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic [11:0] sz;
    logic       cr;
    logic       rdy;
    logic       val;
    logic [7:0] dat;
    logic       last;
    logic       busy;
    logic       err;
  } vec_t;

  function automatic vec_t mk(int v, int d, int l, int sz, int cr,
                              int rdy, int val, int dat, int last, int busy, int err);
    vec_t r;
    r.v = 1'(v);  r.d = 8'(d);  r.l = 1'(l);  r.sz = 12'(sz);  r.cr = 1'(cr);
    r.rdy = 1'(rdy); r.val = 1'(val); r.dat = 8'(dat); r.last = 1'(last);
    r.busy = 1'(busy); r.err = 1'(err);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    i_tmanager_valid       = 1'b0;
    i_tdata                = 8'h00;
    i_tdata_last           = 1'b0;
    i_packet_size_in_bytes = 12'd0;
    i_core_ready           = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, 32'(o_tinput_ready), 32'd0);
    check({tag, "_valid"}, 32'(o_data_valid), 32'd0);
    check({tag, "_last"},  32'(o_input_last), 32'd0);
    check({tag, "_busy"},  32'(o_busy), 32'd0);
    check({tag, "_error"}, 32'(o_error), 32'd0);
    check({tag, "_data"},  32'(o_data), 32'd0);
  endtask

  // Streams one packet with random gaps/back-pressure; entered and left just after a rising edge.
  task automatic run_packet(input logic [7:0] pkt[$], input logic [11:0] size,
                            input int valid_pct, input int ready_pct);
    int n = pkt.size();
    int sent = 0, got = 0, cyc = 0;
    bit busy_m = 1'b0, err_due = 1'b0, last_acc = 1'b0, filled = 1'b0;
    bit wr, rd, err_next;
    acc_got.delete();
    while (got < n && cyc < 2000) begin
      i_tmanager_valid       = (sent < n) && ($urandom_range(99) < valid_pct);
      i_tdata                = (sent < n) ? pkt[sent] : 8'($urandom);
      i_tdata_last           = i_tmanager_valid ? (sent == n - 1) : 1'($urandom_range(1));
      i_packet_size_in_bytes = size;
      i_core_ready           = ($urandom_range(99) < ready_pct);
      @(negedge i_clk);
      check("pkt_error", 32'(o_error), 32'(err_due));
      check("pkt_busy", 32'(o_busy), 32'(busy_m));
      if (!busy_m) begin
        check("idle_ready", 32'(o_tinput_ready), 32'd1);
        check("idle_valid", 32'(o_data_valid), 32'd0);
      end
`ifndef TASK_3_INPUT_CUT_THROUGH_EN
      check("sf_exclusive", 32'(o_tinput_ready && o_data_valid), 32'd0);
`endif
      wr = i_tmanager_valid && o_tinput_ready;
      rd = o_data_valid && i_core_ready;
      err_next = 1'b0;
      if (rd) begin
        check("pkt_data", 32'(o_data), 32'(pkt[got]));
        check("pkt_last", 32'(o_input_last), 32'(got == n - 1));
`ifndef TASK_3_INPUT_CUT_THROUGH_EN
        // Before the last byte arrives, output is only legal once the FIFO has filled.
        if (!last_acc) check("sf_early", 32'(filled), 32'd1);
`endif
        got++;
      end
      if (wr) begin
        acc_got.push_back(got);
        if (sent == n - 1) begin
          last_acc = 1'b1;
          err_next = ((n > 4095 ? 4095 : n) != int'(size));
        end
        sent++;
        busy_m = 1'b1;
      end
      if (rd && got == n) busy_m = 1'b0;
      if (sent - got == TB_DEPTH) filled = 1'b1;
      if (sent == got) filled = 1'b0;
      err_due = err_next;
      @(posedge i_clk); #1;
      cyc++;
    end
    check("pkt_delivered", 32'(got), 32'(n));
    drive_idle();
    @(negedge i_clk);
    check("end_busy", 32'(o_busy), 32'd0);
    check("end_ready", 32'(o_tinput_ready), 32'd1);
    check("end_error", 32'(o_error), 32'(err_due));
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("err_width", 32'(o_error), 32'd0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    vec_t tbl[$];
    logic [7:0] pkt[$];
    logic [11:0] sz;
    int n;

    // mk(v, d, l, size, core_ready | ready, valid, data, last, busy, error)
    // 4-byte packet, size 4: clean store-and-forward.
    tbl.push_back(mk(1, 11, 0, 4, 1,  1, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 22, 0, 4, 1,  1, 0,  0, 0, 1, 0));
    tbl.push_back(mk(1, 33, 0, 4, 1,  1, 0,  0, 0, 1, 0));
    tbl.push_back(mk(1, 44, 1, 4, 1,  1, 0,  0, 0, 1, 0));
    tbl.push_back(mk(0,  0, 0, 4, 1,  0, 1, 11, 0, 1, 0));
    tbl.push_back(mk(0,  0, 0, 4, 1,  0, 1, 22, 0, 1, 0));
    tbl.push_back(mk(0,  0, 0, 4, 1,  0, 1, 33, 0, 1, 0));
    tbl.push_back(mk(0,  0, 0, 4, 1,  0, 1, 44, 1, 1, 0));
    // Same bytes, size 5 on the first byte only: error pulse after the last transfer.
    tbl.push_back(mk(1, 11, 0, 5, 1,  1, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 22, 0, 4, 1,  1, 0,  0, 0, 1, 0));
    tbl.push_back(mk(1, 33, 0, 4, 1,  1, 0,  0, 0, 1, 0));
    tbl.push_back(mk(1, 44, 1, 4, 1,  1, 0,  0, 0, 1, 0));
    tbl.push_back(mk(0,  0, 0, 4, 1,  0, 1, 11, 0, 1, 1));
    tbl.push_back(mk(0,  0, 0, 4, 1,  0, 1, 22, 0, 1, 0));
    tbl.push_back(mk(0,  0, 0, 4, 1,  0, 1, 33, 0, 1, 0));
    tbl.push_back(mk(0,  0, 0, 4, 1,  0, 1, 44, 1, 1, 0));
    // Single-byte packet held by the core for 3 cycles; stray manager bytes ignored.
    tbl.push_back(mk(1, 'hA5, 1, 1, 1,  1, 0,    0, 0, 0, 0));
    tbl.push_back(mk(1, 'hEE, 1, 1, 0,  0, 1, 'hA5, 1, 1, 0));
    tbl.push_back(mk(1, 'hEE, 1, 1, 0,  0, 1, 'hA5, 1, 1, 0));
    tbl.push_back(mk(0,    0, 1, 1, 0,  0, 1, 'hA5, 1, 1, 0));
    tbl.push_back(mk(0,    0, 0, 1, 1,  0, 1, 'hA5, 1, 1, 0));
    // last without valid must not start anything.
    tbl.push_back(mk(0,    0, 1, 9, 1,  1, 0,    0, 0, 0, 0));
    tbl.push_back(mk(0,    0, 0, 9, 1,  1, 0,    0, 0, 0, 0));

    i_rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    check_zero_outputs("rst");
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      i_tmanager_valid       = tbl[i].v;
      i_tdata                = tbl[i].d;
      i_tdata_last           = tbl[i].l;
      i_packet_size_in_bytes = tbl[i].sz;
      i_core_ready           = tbl[i].cr;
      @(negedge i_clk);
      check($sformatf("t%0d_ready", i), 32'(o_tinput_ready), 32'(tbl[i].rdy));
      check($sformatf("t%0d_valid", i), 32'(o_data_valid), 32'(tbl[i].val));
      check($sformatf("t%0d_last", i),  32'(o_input_last), 32'(tbl[i].last));
      check($sformatf("t%0d_busy", i),  32'(o_busy), 32'(tbl[i].busy));
      check($sformatf("t%0d_error", i), 32'(o_error), 32'(tbl[i].err));
      if (tbl[i].val) check($sformatf("t%0d_data", i), 32'(o_data), 32'(tbl[i].dat));
      @(posedge i_clk); #1;
    end
    drive_idle();

    // 6-byte packet into a 4-deep FIFO: bytes 1..4 flush out before 5 is accepted.
    pkt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    run_packet(pkt, 12'd6, 100, 100);
`ifndef TASK_3_INPUT_CUT_THROUGH_EN
    check("flush_before_5", 32'(acc_got[4]), 32'd4);
`endif

    // Reset after 3 of 5 bytes discards them.
    for (int i = 0; i < 3; i++) begin
      i_tmanager_valid       = 1'b1;
      i_tdata                = 8'(i + 1);
      i_tdata_last           = 1'b0;
      i_packet_size_in_bytes = 12'd5;
      i_core_ready           = 1'b1;
      @(negedge i_clk);
      check("mid_ready", 32'(o_tinput_ready), 32'd1);
      @(posedge i_clk); #1;
    end
    i_rst   = 1'b1;
    i_tdata = 8'd4;
    @(negedge i_clk);
    check_zero_outputs("midrst_a");
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_zero_outputs("midrst_b");
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    drive_idle();
    @(negedge i_clk);
    check("post_rst_ready", 32'(o_tinput_ready), 32'd1);
    check("post_rst_busy", 32'(o_busy), 32'd0);
    check("post_rst_valid", 32'(o_data_valid), 32'd0);
    @(posedge i_clk); #1;
    pkt = '{8'd7, 8'd8};
    run_packet(pkt, 12'd2, 100, 100);

`ifdef TASK_3_INPUT_CUT_THROUGH_EN
    pkt = '{8'd1, 8'd2, 8'd3};
    run_packet(pkt, 12'd3, 100, 100);
    check("ct_overlap", 32'(acc_got[2] >= 1), 32'd1);
`endif

    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 10);
      pkt.delete();
      for (int k = 0; k < n; k++) pkt.push_back(8'($urandom));
      if ($urandom_range(3) == 0) sz = ($urandom_range(1) == 1) ? 12'd0 : 12'($urandom_range(1, 12));
      else sz = 12'(n);
      run_packet(pkt, sz, $urandom_range(40, 100), $urandom_range(30, 100));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
